// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_arith_pkg;

  // Control states of the serial sequencer.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a bit counter that indexes 0 .. width-1.
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/fs.sv
// One-bit full subtractor cell: d = x - y - bi, with borrow-out bo.
// Latency: purely combinational.
// Backpressure: none.
// Ports: x minuend bit, y subtrahend bit, bi borrow-in; d difference bit, bo borrow-out.
module fs (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  // Borrow when y exceeds x outright, or when they are equal and a borrow is pending.
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one bit per clock through one fs cell.
// Latency: start accepted at edge E0, valid high in the cycle after edge E_WIDTH; one result per WIDTH+2 cycles.
// Backpressure: ready is high only in IDLE; start outside IDLE is ignored, valid is a one-cycle pulse.
// Ports: clk, rst_n (async active-low); start/a/b/bin request; ready, valid, diff, bout, ovf results.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state_q;
  state_t           state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             br_q;
  // Only WIDTH-1 partial bits need storing: the bit produced on the final
  // edge is taken straight from the cell into the output register.
  logic [WIDTH-2:0] sh_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             ovf_q;

  logic             bit_a;
  logic             bit_b;
  logic             cell_d;
  logic             cell_bo;
  logic             last_bit;
  logic [WIDTH-1:0] sh_next;

  assign bit_a    = a_q[cnt_q];
  assign bit_b    = b_q[cnt_q];
  assign last_bit = (cnt_q == CW'(WIDTH - 1));
  // New bit enters at the MSB side; after WIDTH shifts bit 0 sits in position 0.
  assign sh_next  = {cell_d, sh_q};

  fs u_fs (
    .x  (bit_a),
    .y  (bit_b),
    .bi (br_q),
    .d  (cell_d),
    .bo (cell_bo)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)    state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, serial datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      br_q   <= 1'b0;
      sh_q   <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            br_q  <= bin;
            cnt_q <= '0;
            sh_q  <= '0;
          end
        end
        RUN: begin
          sh_q <= sh_next[WIDTH-1:1];
          br_q <= cell_bo;
          if (last_bit) begin
            cnt_q  <= '0;
            diff_q <= sh_next;
            bout_q <= cell_bo;
            // Signed overflow: operand signs differ and the result sign
            // disagrees with the minuend.
            ovf_q  <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (cell_d ^ a_q[WIDTH-1]);
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign ready = (state_q == IDLE);
  assign valid = (state_q == DONE);
  assign diff  = diff_q;
  assign bout  = bout_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       bin4 = 1'b0;
  logic       ready4, valid4, bout4, ovf4;
  logic [3:0] diff4;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       bin8 = 1'b0;
  logic       ready8, valid8, bout8, ovf8;
  logic [7:0] diff8;

  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .ready(ready4), .valid(valid4), .diff(diff4), .bout(bout4), .ovf(ovf4)
  );

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .ready(ready8), .valid(valid8), .diff(diff8), .bout(bout8), .ovf(ovf8)
  );

  typedef struct {
    int     d;
    int     bo;
    int     ov;
    longint acc;
  } exp_t;

  exp_t   q4[$];
  exp_t   q8[$];
  longint cyc = 0;
  int     n_tests = 0;
  int     n_fail  = 0;
  int     nval4 = 0, nval8 = 0;
  bit     pv4 = 0, pv8 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic exp_t model(input int w, input int a, input int b, input int bi, input longint c);
    exp_t e;
    int lim, sa, sb, sr;
    lim  = 1 << (w - 1);
    e.d  = (a - b - bi) & ((1 << w) - 1);
    e.bo = (a < b + bi) ? 1 : 0;
    sa   = (a >= lim) ? a - 2 * lim : a;
    sb   = (b >= lim) ? b - 2 * lim : b;
    sr   = sa - sb - bi;
    e.ov = (sr < -lim || sr >= lim) ? 1 : 0;
    e.acc = c;
    return e;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard push on every accepted request.
  always @(posedge clk) begin
    if (rst_n && start4 && ready4) q4.push_back(model(4, int'(a4), int'(b4), int'(bin4), cyc));
    if (rst_n && start8 && ready8) q8.push_back(model(8, int'(a8), int'(b8), int'(bin8), cyc));
  end

  // Monitors: compare whenever a result is presented.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      pv4 = 0;
    end else begin
      if (pv4) chk("ready_after_valid4", ready4, 1);
      if (valid4) begin
        nval4++;
        chk("ready_low_in_done4", ready4, 0);
        if (q4.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_valid4: valid=1 with no pending request, diff=%0d", diff4);
        end else begin
          e = q4.pop_front();
          chk("diff4", diff4, e.d);
          chk("bout4", bout4, e.bo);
          chk("ovf4", ovf4, e.ov);
          chk("latency4", cyc - e.acc, 5);
        end
      end
      pv4 = valid4;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      pv8 = 0;
    end else begin
      if (pv8) chk("ready_after_valid8", ready8, 1);
      if (valid8) begin
        nval8++;
        chk("ready_low_in_done8", ready8, 0);
        if (q8.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_valid8: valid=1 with no pending request, diff=%0d", diff8);
        end else begin
          e = q8.pop_front();
          chk("diff8", diff8, e.d);
          chk("bout8", bout8, e.bo);
          chk("ovf8", ovf8, e.ov);
          chk("latency8", cyc - e.acc, 9);
        end
      end
      pv8 = valid8;
    end
  end

  task automatic op4(input int a, input int b, input int bi);
    int n = 0;
    while (ready4 !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    if (ready4 !== 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL ready_timeout4: ready=%b, expected 1", ready4);
    end
    a4 = 4'(a); b4 = 4'(b); bin4 = 1'(bi); start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
  endtask

  task automatic op8(input int a, input int b, input int bi);
    int n = 0;
    while (ready8 !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    if (ready8 !== 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL ready_timeout8: ready=%b, expected 1", ready8);
    end
    a8 = 8'(a); b8 = 8'(b); bin8 = 1'(bi); start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((q4.size() != 0 || q8.size() != 0) && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    int order[512];
    int base;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset_diff4", diff4, 0);
    chk("reset_bout4", bout4, 0);
    chk("reset_ovf4", ovf4, 0);
    chk("reset_valid4", valid4, 0);
    chk("reset_diff8", diff8, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready4", ready4, 1);
    chk("reset_ready8", ready8, 1);

    // Directed cases.
    op4(7, 3, 0);
    op4(3, 7, 0);
    op4(0, 0, 1);
    op4(8, 1, 0);
    drain();

    // start held high with operands changing every cycle.
    base = nval4;
    for (int i = 0; i < 60; i++) begin
      start4 = 1'b1;
      a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
      @(negedge clk);
    end
    start4 = 1'b0;
    drain();
    chk("held_start_results", nval4 - base, 10);

    // Reset in the middle of an operation, after two bits.
    op4(8, 1, 0);
    drain();
    op4(13, 2, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    q4.delete();
    #1;
    chk("midreset_diff4", diff4, 0);
    chk("midreset_bout4", bout4, 0);
    chk("midreset_ovf4", ovf4, 0);
    chk("midreset_valid4", valid4, 0);
    @(negedge clk);
    rst_n = 1'b1;
    base = nval4;
    @(negedge clk);
    chk("midreset_ready4", ready4, 1);
    repeat (8) @(negedge clk);
    chk("midreset_no_valid4", nval4 - base, 0);
    op4(5, 2, 1);
    drain();

    // Full sweep of every (a, b, bin) at WIDTH=4 in random order.
    for (int i = 0; i < 512; i++) order[i] = i;
    for (int i = 511; i > 0; i--) begin
      int j, t;
      j = int'($urandom_range(i, 0));
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    for (int i = 0; i < 512; i++) op4((order[i] >> 5) & 15, (order[i] >> 1) & 15, order[i] & 1);
    drain();

    // WIDTH=8 spot checks.
    op8(0, 0, 1);
    op8(128, 1, 0);
    op8(127, 255, 0);
    op8(255, 255, 1);
    for (int i = 0; i < 40; i++) op8(int'($urandom_range(255, 0)), int'($urandom_range(255, 0)), int'($urandom_range(1, 0)));
    drain();

    chk("pending4", q4.size(), 0);
    chk("pending8", q8.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
